// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one main memory between instruction fetch (I) and load/store (D).
// Round-robin or D-first fixed priority; responses are registered and arrive one cycle later.
module mem_arbiter #(
  parameter int unsigned width          = 32,
  parameter int unsigned addr_width     = 32,
  parameter bit          fixed_priority = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [addr_width-1:0] i_req_addr,
  output logic                  i_resp_valid,
  output logic [width-1:0]      i_resp_data,

  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [addr_width-1:0] d_req_addr,
  input  logic [width-1:0]      d_req_wdata,
  output logic                  d_resp_valid,
  output logic [width-1:0]      d_resp_data,

  output logic [addr_width-1:0] mem_read_address,
  input  logic [width-1:0]      mem_read_data,
  output logic [addr_width-1:0] mem_write_address,
  output logic [width-1:0]      mem_write_data,
  output logic                  mem_write_enable
);

  // rr_ptr: 0 = I wins a collision, 1 = D wins a collision.
  logic             rr_ptr_q, rr_ptr_d;
  logic             grant_i, grant_d;
  logic             i_resp_valid_q, i_resp_valid_d;
  logic [width-1:0] i_resp_data_q, i_resp_data_d;
  logic             d_resp_valid_q, d_resp_valid_d;
  logic [width-1:0] d_resp_data_q, d_resp_data_d;

  // Grants are gated by rst so nothing is accepted while reset is held.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst) begin
      if (i_req_valid && d_req_valid) begin
        if (fixed_priority || rr_ptr_q) begin
          grant_d = 1'b1;
        end else begin
          grant_i = 1'b1;
        end
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_write_enable  = 1'b0;
    if (grant_i) begin
      mem_read_address = i_req_addr;
    end else if (grant_d) begin
      mem_read_address  = d_req_addr;
      mem_write_address = d_req_addr;
      mem_write_data    = d_req_wdata;
      mem_write_enable  = d_req_we;
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    i_resp_valid_d = grant_i;
    i_resp_data_d  = i_resp_data_q;
    d_resp_valid_d = grant_d;
    d_resp_data_d  = d_resp_data_q;
    if (grant_i) begin
      rr_ptr_d      = 1'b1;
      i_resp_data_d = mem_read_data;
    end
    if (grant_d) begin
      rr_ptr_d      = 1'b0;
      d_resp_data_d = d_req_we ? '0 : mem_read_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q       <= 1'b0;
      i_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_valid_q <= 1'b0;
      d_resp_data_q  <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_resp_data_q  <= i_resp_data_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_data_q  <= d_resp_data_d;
    end
  end

  assign i_resp_valid = i_resp_valid_q;
  assign i_resp_data  = i_resp_data_q;
  assign d_resp_valid = d_resp_valid_q;
  assign d_resp_data  = d_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a round-robin and a fixed-priority instance, each with its own
// memory, checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          i_req_valid [2];
  logic          i_req_ready [2];
  logic [AW-1:0] i_req_addr [2];
  logic          i_resp_valid [2];
  logic [W-1:0]  i_resp_data [2];
  logic          d_req_valid [2];
  logic          d_req_ready [2];
  logic          d_req_we [2];
  logic [AW-1:0] d_req_addr [2];
  logic [W-1:0]  d_req_wdata [2];
  logic          d_resp_valid [2];
  logic [W-1:0]  d_resp_data [2];
  logic [AW-1:0] mem_read_address [2];
  logic [W-1:0]  mem_read_data [2];
  logic [AW-1:0] mem_write_address [2];
  logic [W-1:0]  mem_write_data [2];
  logic          mem_write_enable [2];

  logic [W-1:0]  mem [2][256];

  // Reference model state
  logic [W-1:0]  m_mem [2][256];
  logic          m_last_d [2];
  logic          exp_iv [2];
  logic [W-1:0]  exp_id [2];
  logic          exp_dv [2];
  logic [W-1:0]  exp_dd [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.width(W), .addr_width(AW), .fixed_priority(1'b0)) u_rr (
    .clk               (clk),
    .rst               (rst),
    .i_req_valid       (i_req_valid[0]),
    .i_req_ready       (i_req_ready[0]),
    .i_req_addr        (i_req_addr[0]),
    .i_resp_valid      (i_resp_valid[0]),
    .i_resp_data       (i_resp_data[0]),
    .d_req_valid       (d_req_valid[0]),
    .d_req_ready       (d_req_ready[0]),
    .d_req_we          (d_req_we[0]),
    .d_req_addr        (d_req_addr[0]),
    .d_req_wdata       (d_req_wdata[0]),
    .d_resp_valid      (d_resp_valid[0]),
    .d_resp_data       (d_resp_data[0]),
    .mem_read_address  (mem_read_address[0]),
    .mem_read_data     (mem_read_data[0]),
    .mem_write_address (mem_write_address[0]),
    .mem_write_data    (mem_write_data[0]),
    .mem_write_enable  (mem_write_enable[0])
  );

  mem_arbiter #(.width(W), .addr_width(AW), .fixed_priority(1'b1)) u_fp (
    .clk               (clk),
    .rst               (rst),
    .i_req_valid       (i_req_valid[1]),
    .i_req_ready       (i_req_ready[1]),
    .i_req_addr        (i_req_addr[1]),
    .i_resp_valid      (i_resp_valid[1]),
    .i_resp_data       (i_resp_data[1]),
    .d_req_valid       (d_req_valid[1]),
    .d_req_ready       (d_req_ready[1]),
    .d_req_we          (d_req_we[1]),
    .d_req_addr        (d_req_addr[1]),
    .d_req_wdata       (d_req_wdata[1]),
    .d_resp_valid      (d_resp_valid[1]),
    .d_resp_data       (d_resp_data[1]),
    .mem_read_address  (mem_read_address[1]),
    .mem_read_data     (mem_read_data[1]),
    .mem_write_address (mem_write_address[1]),
    .mem_write_data    (mem_write_data[1]),
    .mem_write_enable  (mem_write_enable[1])
  );

  function automatic logic [W-1:0] init_word(input int k, input int a);
    if (a == 16) return 32'hDEADBEEF;
    return (a * 32'h01010101) ^ (k * 32'h5A5A0000) ^ 32'h00001234;
  endfunction

  // Memories reload their initial image whenever reset is held across a clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= init_word(k, a);
      end else if (mem_write_enable[k]) begin
        mem[k][mem_write_address[k][7:0]] <= mem_write_data[k];
      end
    end
  end

  assign mem_read_data[0] = mem[0][mem_read_address[0][7:0]];
  assign mem_read_data[1] = mem[1][mem_read_address[1][7:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) m_mem[k][a] = init_word(k, a);
      m_last_d[k] = 1'b1;  // pretend D went last so I wins the first collision
      exp_iv[k] = 1'b0;
      exp_id[k] = '0;
      exp_dv[k] = 1'b0;
      exp_dd[k] = '0;
    end
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < 2; k++) begin
      i_req_valid[k] = 1'b0;
      i_req_addr[k]  = '0;
      d_req_valid[k] = 1'b0;
      d_req_we[k]    = 1'b0;
      d_req_addr[k]  = '0;
      d_req_wdata[k] = '0;
    end
  endtask

  task automatic req_i(input int k, input logic [AW-1:0] a);
    i_req_valid[k] = 1'b1;
    i_req_addr[k]  = a;
  endtask

  task automatic req_d(input int k, input logic we, input logic [AW-1:0] a, input logic [W-1:0] wd);
    d_req_valid[k] = 1'b1;
    d_req_we[k]    = we;
    d_req_addr[k]  = a;
    d_req_wdata[k] = wd;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom & 32'hF000_0000) | AW'($urandom_range(0, 15));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_reqs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One bus cycle on instance k: called just after a falling edge with requests already driven.
  task automatic step(input int k);
    logic          gi, gd, both;
    logic [AW-1:0] ra;
    logic [W-1:0]  rd;
    #1;
    both = i_req_valid[k] && d_req_valid[k];
    if (!rst) begin
      gi = 1'b0;
    end else if (both) begin
      gi = (k == 0) && m_last_d[k];  // fixed-priority instance always favours D
    end else begin
      gi = i_req_valid[k];
    end
    gd = rst && d_req_valid[k] && !gi;
    ra = gi ? i_req_addr[k] : (gd ? d_req_addr[k] : '0);
    rd = m_mem[k][ra[7:0]];
    check_eq("i_req_ready", 32'(i_req_ready[k]), 32'(gi));
    check_eq("d_req_ready", 32'(d_req_ready[k]), 32'(gd));
    check_eq("mem_read_address", mem_read_address[k], ra);
    check_eq("mem_write_enable", 32'(mem_write_enable[k]), 32'(gd && d_req_we[k]));
    check_eq("mem_write_address", mem_write_address[k], gd ? d_req_addr[k] : '0);
    check_eq("mem_write_data", mem_write_data[k], gd ? d_req_wdata[k] : '0);
    @(posedge clk);
    exp_iv[k] = gi;
    exp_dv[k] = gd;
    if (gi) begin
      exp_id[k]   = rd;
      m_last_d[k] = 1'b0;
    end
    if (gd) begin
      exp_dd[k]   = d_req_we[k] ? '0 : rd;
      m_last_d[k] = 1'b1;
      if (d_req_we[k]) m_mem[k][d_req_addr[k][7:0]] = d_req_wdata[k];
    end
    @(negedge clk);
    if (gi) i_req_valid[k] = 1'b0;
    if (gd) d_req_valid[k] = 1'b0;
    check_eq("i_resp_valid", 32'(i_resp_valid[k]), 32'(exp_iv[k]));
    check_eq("i_resp_data", i_resp_data[k], exp_id[k]);
    check_eq("d_resp_valid", 32'(d_resp_valid[k]), 32'(exp_dv[k]));
    check_eq("d_resp_data", d_resp_data[k], exp_dd[k]);
  endtask

  task automatic random_reqs(input int k, input int pct);
    if (!i_req_valid[k] && ($urandom_range(0, 99) < pct)) req_i(k, rand_addr());
    if (!d_req_valid[k] && ($urandom_range(0, 99) < pct)) begin
      req_d(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
  endtask

  initial begin
    clear_reqs();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state
    check_eq("reset_i_resp_valid", 32'(i_resp_valid[0]), 32'd0);
    check_eq("reset_d_resp_data", d_resp_data[0], 32'd0);

    // Lone fetch of 0x10
    req_i(0, 32'h10);
    step(0);
    check_eq("fetch_0x10_data", i_resp_data[0], 32'hDEADBEEF);

    // Both ports valid every cycle: I, D, I, D
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (!i_req_valid[0]) req_i(0, rand_addr());
      if (!d_req_valid[0]) req_d(0, 1'b0, rand_addr(), '0);
      step(0);
      check_eq("alternate_i_resp", 32'(i_resp_valid[0]), 32'((c % 2) == 0));
    end
    clear_reqs();

    // Fixed priority: D wins three collisions, then I goes once D drops
    for (int c = 0; c < 3; c++) begin
      req_i(1, 32'h40);
      req_d(1, 1'b0, 32'h50 + c, '0);
      step(1);
      check_eq("fixed_d_resp", 32'(d_resp_valid[1]), 32'd1);
    end
    step(1);
    check_eq("fixed_i_after_drop", 32'(i_resp_valid[1]), 32'd1);

    // Write 0x20 then read it back through I the very next cycle
    req_d(0, 1'b1, 32'h20, 32'h12345678);
    step(0);
    check_eq("write_ack_data", d_resp_data[0], 32'd0);
    req_i(0, 32'h20);
    step(0);
    check_eq("read_after_write", i_resp_data[0], 32'h12345678);

    // Idle gap: nothing moves, no pulses
    for (int c = 0; c < 5; c++) step(0);

    // Reset lands right after a D read is accepted
    req_d(0, 1'b0, 32'h30, '0);
    req_i(0, 32'h31);
    #1;
    check_eq("pre_reset_d_ready", 32'(d_req_ready[0]), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rst_d_resp_valid", 32'(d_resp_valid[0]), 32'd0);
    check_eq("rst_i_ready", 32'(i_req_ready[0]), 32'd0);
    check_eq("rst_d_ready", 32'(d_req_ready[0]), 32'd0);
    check_eq("rst_mem_we", 32'(mem_write_enable[0]), 32'd0);
    d_req_we[0] = 1'b1;
    @(negedge clk);
    check_eq("rst_we_forced_low", 32'(mem_write_enable[0]), 32'd0);
    check_eq("rst_d_ready_hold", 32'(d_req_ready[0]), 32'd0);
    @(negedge clk);
    check_eq("rst_no_late_resp", 32'(d_resp_valid[0]), 32'd0);
    clear_reqs();
    rst = 1'b1;
    step(0);
    req_i(0, 32'h10);
    req_d(0, 1'b0, 32'h11, '0);
    step(0);
    check_eq("post_rst_i_first", 32'(i_resp_valid[0]), 32'd1);
    step(0);

    // Randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      clear_reqs();
      for (int c = 0; c < 400; c++) begin
        random_reqs(k, (c % 50) < 40 ? 70 : 0);
        step(k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
